// File: rtl/pio_poller_pkg.sv
// rtl/pio_poller_pkg.sv - shared types and helpers for the PIO input poller
package pio_poller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bits needed to hold the values 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - debounce captured PIO samples and publish committed value with edge masks
module pio_debounce
  import pio_poller_pkg::*;
#(
  parameter int DATA_WIDTH   = 5,
  parameter int STABLE_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  event_pulse
);

  localparam int            SW     = cnt_width(STABLE_COUNT + 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STABLE_COUNT);
  localparam logic [SW-1:0] ONE    = SW'(1);

  logic [DATA_WIDTH-1:0] candidate;
  logic [DATA_WIDTH-1:0] cand_next;
  logic [SW-1:0]         stable_cnt;
  logic [SW-1:0]         cnt_next;

  always_comb begin
    cand_next = candidate;
    cnt_next  = stable_cnt;
    if (sample == candidate) begin
      if (stable_cnt != SC_MAX) cnt_next = stable_cnt + ONE;
    end else begin
      cand_next = sample;
      cnt_next  = ONE;
    end
  end

  // Commit is decided from the post-update candidate so it lands in the cycle after capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      candidate   <= '0;
      stable_cnt  <= '0;
      value       <= '0;
      rise        <= '0;
      fall        <= '0;
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      if (sample_valid) begin
        candidate  <= cand_next;
        stable_cnt <= cnt_next;
        if (cnt_next == SC_MAX && cand_next != value) begin
          value       <= cand_next;
          rise        <= cand_next & ~value;
          fall        <= ~cand_next & value;
          event_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_in_poller.sv
// rtl/pio_in_poller.sv - Avalon-MM poller for the button/switch PIO; PIO_POLLER_OVERRUN_EN adds overrun flag
module pio_in_poller
  import pio_poller_pkg::*;
#(
  parameter int DATA_WIDTH   = 5,
  parameter int POLL_PERIOD  = 50000,
  parameter int READ_LATENCY = 1,
  parameter int STABLE_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  event_pulse
`ifdef PIO_POLLER_OVERRUN_EN
  ,
  input  logic                  overrun_clr,
  output logic                  overrun
`endif
);

  localparam int            PW          = cnt_width(POLL_PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
  localparam logic [1:0]    RL_CNT      = 2'(READ_LATENCY);

  poll_state_t   state;
  poll_state_t   state_next;
  logic [PW-1:0] period_cnt;
  logic [1:0]    lat_cnt;
  logic          tick;
  logic          sample_valid;
  logic [31:0]   unused_readdata;

  assign unused_readdata = avm_readdata;
  assign tick = enable && (period_cnt == PERIOD_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) period_cnt <= '0;
    else if (tick)           period_cnt <= '0;
    else                     period_cnt <= period_cnt + PERIOD_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      state <= state_next;
      if (state == REQ && !avm_waitrequest) lat_cnt <= 2'd1;
      else if (state == WAIT)               lat_cnt <= lat_cnt + 2'd1;
    end
  end

  // Enable only gates the tick; a transaction already issued always runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = REQ;
      REQ:     if (!avm_waitrequest) state_next = (READ_LATENCY == 0) ? IDLE : WAIT;
      WAIT:    if (lat_cnt == RL_CNT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    avm_read    = (state == REQ);
    avm_address = PIO_DATA_ADDR;
    if (READ_LATENCY == 0) sample_valid = (state == REQ) && !avm_waitrequest;
    else                   sample_valid = (state == WAIT) && (lat_cnt == RL_CNT);
  end

`ifdef PIO_POLLER_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                    overrun <= 1'b0;
    else if (tick && state != IDLE)  overrun <= 1'b1;
    else if (overrun_clr)            overrun <= 1'b0;
  end
`endif

  pio_debounce #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample      (avm_readdata[DATA_WIDTH-1:0]),
    .value       (value),
    .rise        (rise),
    .fall        (fall),
    .event_pulse (event_pulse)
  );

endmodule

// File: tb/tb_pio_in_poller.sv
// tb/tb_pio_in_poller.sv - self-checking bench for pio_in_poller with a sample-history debounce model
module tb_pio_in_poller;

  localparam int DW = 5;
  localparam int PP = 8;
  localparam int SC = 2;
  localparam int RL = 1;
  localparam logic [DW-1:0] GARBAGE = 5'b11010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = 32'd0;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic [DW-1:0] value, rise, fall;
  logic          event_pulse;
`ifdef PIO_POLLER_OVERRUN_EN
  logic          overrun;
`endif

  pio_in_poller #(.DATA_WIDTH(DW), .POLL_PERIOD(PP), .READ_LATENCY(RL), .STABLE_COUNT(SC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .value(value), .rise(rise), .fall(fall), .event_pulse(event_pulse)
`ifdef PIO_POLLER_OVERRUN_EN
    , .overrun_clr(1'b0), .overrun(overrun)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: stalls on request, returns pio one cycle after acceptance, junk otherwise.
  logic [DW-1:0] pio = '0;
  int            wr_budget = 0;
  logic          acc_q = 1'b0;
  logic          resp_valid = 1'b0;

  always @(posedge clk) begin
    #1;
    resp_valid   = acc_q;
    avm_readdata = {27'($urandom), (acc_q ? pio : GARBAGE)};
    if (avm_read && wr_budget > 0) begin
      avm_waitrequest = 1'b1;
      wr_budget--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // Model: value commits once the last SC samples agree and differ from the committed value.
  logic [DW-1:0] m_value = '0, m_rise = '0, m_fall = '0, m_cand = '0;
  logic          m_event = 1'b0;
  int            m_run = 0;
  logic          model_on = 1'b0;
  int            n_caps = 0, ev_count = 0, n_reads = 0;
  int            cyc = 0, last_rise = 0, prev_rise = 0, cur_len = 0, last_len = 0;
  logic          read_q = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      check("value", 32'(value), 32'(m_value));
      check("rise", 32'(rise), 32'(m_rise));
      check("fall", 32'(fall), 32'(m_fall));
      check("event", 32'(event_pulse), 32'(m_event));
      check("address", 32'(avm_address), 32'd0);
    end
    if (event_pulse === 1'b1) ev_count++;
    if (!reset_n) begin
      m_value = '0; m_rise = '0; m_fall = '0; m_cand = '0; m_event = 1'b0; m_run = 0;
    end else begin
      m_event = 1'b0;
      if (resp_valid) begin
        n_caps++;
        if (pio == m_cand) m_run++;
        else begin
          m_cand = pio;
          m_run  = 1;
        end
        if (m_run >= SC && m_cand != m_value) begin
          m_rise  = m_cand & ~m_value;
          m_fall  = ~m_cand & m_value;
          m_value = m_cand;
          m_event = 1'b1;
        end
      end
    end
    if (avm_read && !read_q) begin
      n_reads++;
      prev_rise = last_rise;
      last_rise = cyc;
      cur_len   = 0;
    end
    if (avm_read) cur_len++;
    else if (read_q) last_len = cur_len;
    read_q = avm_read;
    acc_q  = avm_read && !avm_waitrequest && reset_n;
    cyc++;
  end

  task automatic wait_caps(input int n);
    int target = n_caps + n;
    for (int i = 0; i < 40 * n; i++) begin
      @(posedge clk); #1;
      if (n_caps >= target) return;
    end
    check("capture timeout", 32'(n_caps), 32'(target));
  endtask

  task automatic wait_reads(input int n);
    int target = n_reads + n;
    for (int i = 0; i < 40 * n; i++) begin
      @(posedge clk); #1;
      if (n_reads >= target) return;
    end
    check("read timeout", 32'(n_reads), 32'(target));
  endtask

`ifdef PIO_POLLER_OVERRUN_EN
  logic          o_reset_n = 1'b0, o_wr = 1'b0, o_clr = 1'b0;
  logic          o_read, o_event, o_overrun;
  logic [1:0]    o_addr;
  logic [DW-1:0] o_value, o_rise, o_fall;

  pio_in_poller #(.DATA_WIDTH(DW), .POLL_PERIOD(2), .READ_LATENCY(1), .STABLE_COUNT(SC)) u_ovr (
    .clk(clk), .reset_n(o_reset_n), .enable(1'b1),
    .avm_address(o_addr), .avm_read(o_read),
    .avm_waitrequest(o_wr), .avm_readdata(32'd0),
    .value(o_value), .rise(o_rise), .fall(o_fall), .event_pulse(o_event),
    .overrun_clr(o_clr), .overrun(o_overrun)
  );
`endif

  int rel;
  int ev0;
  int reads0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    check("reset value", 32'(value), 32'd0);
    check("reset event", 32'(event_pulse), 32'd0);
    check("reset read", 32'(avm_read), 32'd0);

    // Idle inputs: periodic single-cycle reads, nothing committed.
    reset_n = 1'b1;
    enable  = 1'b1;
    rel     = cyc;
    wait_reads(1);
    check("first read delay", 32'(last_rise - rel), 32'd8);
    wait_reads(2);
    check("read period", 32'(last_rise - prev_rise), 32'd8);
    check("read width", 32'(last_len), 32'd1);
    wait_caps(1);
    check("zero input value", 32'(value), 32'd0);
    check("zero input events", 32'(ev_count), 32'd0);

    // New pattern needs two agreeing samples.
    ev0 = ev_count;
    pio = 5'b00101;
    wait_caps(1);
    check("first sample no commit", 32'(value), 32'd0);
    check("first sample no event", 32'(event_pulse), 32'd0);
    wait_caps(1);
    check("commit value", 32'(value), 32'h05);
    check("commit rise", 32'(rise), 32'h05);
    check("commit fall", 32'(fall), 32'h00);
    check("commit event", 32'(event_pulse), 32'd1);

    // Glitch: a lone differing sample resets the candidate without committing.
    wait_caps(1);
    pio = 5'b00000;
    wait_caps(1);
    pio = 5'b00101;
    wait_caps(2);
    check("glitch value", 32'(value), 32'h05);
    check("glitch event", 32'(event_pulse), 32'd0);
    check("single event over two tests", 32'(ev_count - ev0), 32'd1);

    // Mixed rise and fall.
    pio = 5'b00011;
    wait_caps(2);
    check("mixed value", 32'(value), 32'h03);
    check("mixed rise", 32'(rise), 32'h02);
    check("mixed fall", 32'(fall), 32'h04);

    // Disabled: no reads; re-enable restarts the period from zero.
    enable = 1'b0;
    reads0 = n_reads;
    repeat (20) @(posedge clk);
    #1;
    check("disabled reads", 32'(n_reads - reads0), 32'd0);
    enable = 1'b1;
    rel    = cyc;
    wait_reads(1);
    check("re-enable delay", 32'(last_rise - rel), 32'd8);
    wait_caps(1);

    // Stalled read: request held through three waitrequest cycles.
    wr_budget = 3;
    pio = 5'b10000;
    wait_caps(1);
    check("stalled read width", 32'(last_len), 32'd4);
    check("stalled no commit", 32'(value), 32'h03);
    wait_caps(1);
    check("stalled value", 32'(value), 32'h10);
    check("stalled rise", 32'(rise), 32'h10);
    check("stalled fall", 32'(fall), 32'h03);

    // Reset during the response cycle discards the response.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (avm_read) break;
    end
    check("sync read seen", 32'(avm_read), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort value", 32'(value), 32'd0);
    check("abort rise", 32'(rise), 32'd0);
    check("abort fall", 32'(fall), 32'd0);
    check("abort read", 32'(avm_read), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rel = cyc;
    wait_reads(1);
    check("post-reset delay", 32'(last_rise - rel), 32'd8);
    wait_caps(1);
    check("discarded response", 32'(value), 32'd0);
    wait_caps(1);
    check("post-reset value", 32'(value), 32'h10);
    check("post-reset rise", 32'(rise), 32'h10);

`ifdef PIO_POLLER_OVERRUN_EN
    check("main overrun", 32'(overrun), 32'd0);
    o_reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      o_wr  = (k >= 2 && k <= 5);
      o_clr = (k == 12 || k == 15);
      if (k == 3)  check("overrun before 2nd tick", 32'(o_overrun), 32'd0);
      if (k == 4)  check("overrun after 2nd tick", 32'(o_overrun), 32'd1);
      if (k == 13) check("overrun cleared", 32'(o_overrun), 32'd0);
      if (k == 14) check("overrun idle tick", 32'(o_overrun), 32'd0);
      if (k == 16) check("overrun set wins", 32'(o_overrun), 32'd1);
      @(posedge clk); #1;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/pio_in_poller.md
Name: pio_in_poller

Overview:
Avalon-MM initiator that drives the 5-bit input PIO responder used for the game buttons/switches.
- Issues a single-word read to address 0 every POLL_PERIOD clocks.
- Debounces the returned bits over STABLE_COUNT consecutive samples.
- Presents the stable value, plus rise/fall masks and a one-cycle event strobe, to game logic.
- Replaces CPU polling of the PIO.

Parameters:
DATA_WIDTH, 5, number of PIO bits used (readdata[DATA_WIDTH-1:0]); 1..32
POLL_PERIOD, 50000, clocks between read issues; >=2
READ_LATENCY, 1, fixed responder read latency in clocks after acceptance; 0..3
STABLE_COUNT, 3, identical consecutive samples required before the value is committed; >=1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  polling enable
avm_address  out  2  Avalon address; constant 0
avm_read  out  1  Avalon read request
avm_waitrequest  in  1  responder stall; tie 0 if unsupported
avm_readdata  in  32  Avalon read data
value  out  DATA_WIDTH  debounced stable value
rise  out  DATA_WIDTH  bits that went 0->1 at the last commit
fall  out  DATA_WIDTH  bits that went 1->0 at the last commit
event  out  1  one-cycle strobe on each commit

Behaviour:
Clock and reset
- Single clock clk; reset is synchronous, active-low on reset_n, sampled at posedge clk.
- Reset values: avm_read=0, avm_address=0, value=0, rise=0, fall=0, event=0, FSM=IDLE, period counter=0, latency counter=0, candidate=0, stable_cnt=0.
- Reset asserted mid-transaction aborts it immediately; no response is captured.

Period counter
- Counts 0..POLL_PERIOD-1 while enable=1, wrapping to 0. The wrap cycle is a "tick".
- Cleared and held at 0 while enable=0.

FSM: IDLE, REQ, WAIT
- IDLE: on tick -> REQ.
- REQ: avm_read=1, avm_address=0.
  - Hold while avm_waitrequest=1.
  - The cycle with avm_waitrequest=0 is acceptance; avm_read drops the next cycle.
  - READ_LATENCY=0: capture avm_readdata in the acceptance cycle, -> IDLE.
  - READ_LATENCY>0: -> WAIT, latency counter=1.
- WAIT: capture avm_readdata[DATA_WIDTH-1:0] when the counter equals READ_LATENCY, i.e. exactly READ_LATENCY cycles after acceptance (1 -> the cycle after acceptance), then -> IDLE.
- enable falling during REQ/WAIT: the transaction completes (avm_read never withdrawn while waitrequest=1); no new tick follows.
- Tick while not IDLE: ignored.

Debounce (on each captured sample s)
- s==candidate: stable_cnt saturating increment, capped at STABLE_COUNT.
- s!=candidate: candidate<=s, stable_cnt<=1.
- Commit: in the cycle after the capture where stable_cnt (post-update) == STABLE_COUNT and candidate != value:
  - value<=candidate
  - rise<=candidate & ~value
  - fall<=~candidate & value
  - event=1 for one cycle
- rise/fall hold until the next commit.
- No commit while the candidate equals value.
- STABLE_COUNT=1 commits on every differing sample.
- avm_readdata bits above DATA_WIDTH are ignored.

Optional Feature:
Macro: PIO_POLLER_OVERRUN_EN.
- Defined:
  - Adds input overrun_clr (1 bit) and output overrun (1 bit, reset 0).
  - overrun is set sticky when a tick occurs with the FSM not IDLE.
  - Cleared by overrun_clr=1; set wins if both occur in the same cycle.
- Undefined: the ports are absent and overlapping ticks are silently dropped.

Decomposition:
Shared package pio_poller_pkg:
- FSM state enum: IDLE, REQ, WAIT.
- Localparam for PIO data address 0.
- Width helper for counters: $clog2 of POLL_PERIOD and of STABLE_COUNT+1.

Sub-module pio_debounce:
- Holds candidate, stable_cnt, value, rise, fall, event.
- Inputs: sample and sample_valid.
- Top level keeps the FSM and period counter.

Test Plan:
All cases use POLL_PERIOD=8, STABLE_COUNT=2, READ_LATENCY=1, DATA_WIDTH=5 unless stated.
1. Reset, enable=1, waitrequest=0, responder returns 5'b00000:
   - avm_read pulses 1 cycle every 8 clocks at address 0.
   - value stays 0; event never asserts.
2. Responder switches to 5'b00101:
   - First read: no event.
   - Second read: value=00101, rise=00101, fall=0, event pulses once.
3. Glitch sequence 00101, 00000, 00101, 00101 starting from value=00101 (candidate=00101):
   - The single 00000 sample resets the candidate but never commits.
   - event stays 0 throughout; value stays 00101.
4. avm_waitrequest held 3 cycles on one read:
   - avm_read and address stay stable for 4 cycles.
   - Data is captured 1 cycle after the cycle where waitrequest=0.
5. Reset_n=0 asserted while in WAIT, released 2 cycles later:
   - All outputs are 0 at the next clock edge.
   - The pending response is discarded.
   - Polling resumes 8 clocks after release.
6. With PIO_POLLER_OVERRUN_EN, POLL_PERIOD=2 and waitrequest held 4 cycles:
   - overrun=1 after the second tick.
   - Clears on overrun_clr=1 when no tick occurs in that cycle.
